dp_ram_clr: RTL
===============

# dp_ram_clr

Parametrised true dual-port synchronous RAM. It is the successor to the fixed 16x1024 `bram` used by the datapath. It adds:
- configurable width and depth,
- a selectable read-during-write mode,
- same-address write collision detection,
- an optional hardware clear sequence after reset.

It sits between the datapath/load-store path (port A) and the I/O or instruction-fetch path (port B). The `ready` output gates both.

## Interface
Parameters:
- `DATA_WIDTH`, 16: word width in bits.
- `ADDR_WIDTH`, 10: address width; DEPTH = 2**ADDR_WIDTH.
- `RDW_MODE`, 0: same-port read-during-write behaviour; 0 = read-first (old data), 1 = write-first (new data).
- `CLEAR_ON_RESET`, 1: 1 = zero every location after reset; 0 = skip the clear.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `data_a`  in  DATA_WIDTH: port A write data.
- `addr_a`  in  ADDR_WIDTH: port A address.
- `we_a`  in  1: port A write enable.
- `q_a`  out  DATA_WIDTH: port A registered read data.
- `data_b`  in  DATA_WIDTH: port B write data.
- `addr_b`  in  ADDR_WIDTH: port B address.
- `we_b`  in  1: port B write enable.
- `q_b`  out  DATA_WIDTH: port B registered read data.
- `ready`  out  1: memory accepts user accesses.
- `collision`  out  1: one-cycle pulse, registered; both ports wrote the same address on the previous edge.

## Operation
- States: CLEAR and RUN.
- Reset (any cycle, including mid-clear or mid-access):
  - `q_a`, `q_b` = 0; `collision` = 0; `ready` = 0.
  - Clear counter = 0.
  - Next state is CLEAR if `CLEAR_ON_RESET`=1, else RUN.
  - Memory contents are not touched by reset itself.
- CLEAR:
  - Each edge with reset low writes 0 to the counter address via port A, then increments the counter.
  - User `we_a`/`we_b` are ignored. `q_a`/`q_b` hold 0. `collision` stays 0.
  - When the write to address DEPTH-1 occurs, transition to RUN and set `ready` to 1 on the same edge.
  - The counter does not wrap back to 0 in CLEAR.
- RUN (`ready`=1), on each edge, per port independently:
  - If `we_x`: `mem[addr_x]` <= `data_x`.
  - `q_x` <= old `mem[addr_x]` when `RDW_MODE`=0.
  - `q_x` <= `data_x` when `RDW_MODE`=1 and `we_x`=1.
  - Otherwise `q_x` <= `mem[addr_x]`.
- Cross-port read of an address written by the other port on the same edge always returns the old contents, in both modes.
- Write collision (`we_a` & `we_b` & `addr_a`==`addr_b`):
  - Port A data is stored; port B's write is dropped.
  - `collision` is 1 for exactly the following cycle.
  - `q_b` returns what port B would return in its mode, except that in write-first mode it returns `data_a`, the stored value.
- Simultaneous reads of the same address by both ports are always legal.

## Timing
- Read latency: 1 cycle. The address is presented before edge N; `q` is valid after edge N.
- Write takes effect at the edge where `we` is sampled high. A read on the next cycle sees the new data.
- Clear duration: exactly DEPTH edges after the first edge with reset low; `ready` is high after edge DEPTH.
- With `CLEAR_ON_RESET`=0, `ready` goes high after the first edge with reset low.
- `collision` is registered and is never high while `ready`=0.

## Structure
- Shared package `mem_pkg`:
  - `RDW_READ_FIRST`=0 and `RDW_WRITE_FIRST`=1.
  - State encoding `ST_CLEAR`, `ST_RUN`.
- Sub-module `dp_ram_core` is a plain inferable two-port array with per-port `we`, registered `q`, and the `RDW_MODE` parameter.
- Top level `dp_ram_clr` holds:
  - the clear FSM and counter,
  - the port-A mux (clear vs user),
  - the write-enable gating,
  - the collision detect and register,
  - forcing `q` to 0 outside RUN.

## Test plan
Benches use ADDR_WIDTH=4 (DEPTH=16) and DATA_WIDTH=16 unless noted.
- Clear:
  - Stimulus: preload `mem[5]`=0xBEEF, then reset for 1 cycle.
  - Required: `ready` is low for 16 edges and rises after edge 16; reading address 5 then returns 0x0000; `we_a` asserted during clear has no effect.
- Dual write and readback:
  - Stimulus: A writes 0x000F to addr 0 while B writes 0x3000 to addr 2; next cycle, swap the addresses and read.
  - Required: `q_a`=0x3000 and `q_b`=0x000F after one edge.
- Read-during-write:
  - Stimulus: `mem[1]`=0x00F0, then A writes 0x0030 to addr 1.
  - Required: `q_a`=0x00F0 with `RDW_MODE`=0; `q_a`=0x0030 with `RDW_MODE`=1; port B reading addr 1 on the same edge gets 0x00F0 in both modes.
- Collision:
  - Stimulus: both ports write addr 3 with A=0x1111, B=0x2222.
  - Required: `collision`=1 for exactly one cycle; a later read of addr 3 gives 0x1111.
- Reset mid-clear:
  - Stimulus: assert reset at clear edge 7.
  - Required: `ready`=0, `q`=0, and the clear restarts at address 0, taking 16 further edges.
- `CLEAR_ON_RESET`=0:
  - Required: `ready`=1 after the first edge with reset low, and preloaded `mem[5]`=0xBEEF is preserved.

Source files
------------

// File: rtl/dp_ram_clr_pkg.sv
// rtl/dp_ram_clr_pkg.sv - shared constants and state encoding for the clearable dual-port RAM
package mem_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/dp_ram_clr_if.sv
// rtl/dp_ram_clr_if.sv - user-side bus of both RAM ports plus ready/collision status
interface dp_ram_clr_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
);
    logic [DATA_WIDTH-1:0] data_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic                  we_a;
    logic [DATA_WIDTH-1:0] q_a;
    logic [DATA_WIDTH-1:0] data_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic                  we_b;
    logic [DATA_WIDTH-1:0] q_b;
    logic                  ready;
    logic                  collision;

    modport master (
        output data_a, addr_a, we_a, data_b, addr_b, we_b,
        input  q_a, q_b, ready, collision
    );

    modport slave (
        input  data_a, addr_a, we_a, data_b, addr_b, we_b,
        output q_a, q_b, ready, collision
    );
endinterface

// File: rtl/dp_ram_clr_core.sv
// rtl/dp_ram_clr_core.sv - plain inferable two-port array, registered reads, no reset
module dp_ram_core
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int RDW_MODE   = RDW_READ_FIRST
) (
    input  logic                  clk_i,
    input  logic                  we_a_i,
    input  logic [ADDR_WIDTH-1:0] addr_a_i,
    input  logic [DATA_WIDTH-1:0] din_a_i,
    output logic [DATA_WIDTH-1:0] q_a_o,
    input  logic                  we_b_i,
    input  logic [ADDR_WIDTH-1:0] addr_b_i,
    input  logic [DATA_WIDTH-1:0] din_b_i,
    output logic [DATA_WIDTH-1:0] q_b_o
);
    localparam int DEPTH = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] q_a_q;
    logic [DATA_WIDTH-1:0] q_b_q;

    // Cross-port reads see the old word because array updates are non-blocking.
    always_ff @(posedge clk_i) begin
        if (we_a_i) begin
            mem_q[addr_a_i] <= din_a_i;
        end
        if (we_b_i) begin
            mem_q[addr_b_i] <= din_b_i;
        end
        if (RDW_MODE == RDW_WRITE_FIRST && we_a_i) begin
            q_a_q <= din_a_i;
        end else begin
            q_a_q <= mem_q[addr_a_i];
        end
        if (RDW_MODE == RDW_WRITE_FIRST && we_b_i) begin
            q_b_q <= din_b_i;
        end else begin
            q_b_q <= mem_q[addr_b_i];
        end
    end

    assign q_a_o = q_a_q;
    assign q_b_o = q_b_q;

endmodule

// File: rtl/dp_ram_clr.sv
// rtl/dp_ram_clr.sv - dual-port RAM with post-reset clear sequence and write collision detect
module dp_ram_clr
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 10,
    parameter int RDW_MODE       = RDW_READ_FIRST,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic         clk,
    input  logic         reset,
    dp_ram_clr_if.slave  bus
);
    localparam int                    DEPTH       = depth_of(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
    localparam state_e                RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  q_valid_q, q_valid_d;
    logic                  collision_q, collision_d;

    logic                  clearing;
    logic                  user_ok;
    logic                  core_we_a;
    logic [ADDR_WIDTH-1:0] core_addr_a;
    logic [DATA_WIDTH-1:0] core_din_a;
    logic                  core_we_b;
    logic [DATA_WIDTH-1:0] core_q_a;
    logic [DATA_WIDTH-1:0] core_q_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            q_valid_q   <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            q_valid_q   <= q_valid_d;
            collision_q <= collision_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        clearing    = (state_q == ST_CLEAR) && !reset;
        // A reset edge must never disturb memory, even when it lands mid-access.
        user_ok     = ready_q && !reset;
        collision_d = user_ok && bus.we_a && bus.we_b && (bus.addr_a == bus.addr_b);
        q_valid_d   = user_ok;

        unique case (state_q)
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_RUN: begin
                ready_d = 1'b1;
            end
        endcase

        core_we_a   = clearing || (user_ok && bus.we_a);
        core_addr_a = clearing ? cnt_q : bus.addr_a;
        core_din_a  = clearing ? '0 : bus.data_a;
        // Port A wins a same-address write; port B's write is simply dropped.
        core_we_b   = user_ok && bus.we_b && !collision_d;
    end

    dp_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RDW_MODE   (RDW_MODE)
    ) u_core (
        .clk_i    (clk),
        .we_a_i   (core_we_a),
        .addr_a_i (core_addr_a),
        .din_a_i  (core_din_a),
        .q_a_o    (core_q_a),
        .we_b_i   (core_we_b),
        .addr_b_i (bus.addr_b),
        .din_b_i  (bus.data_b),
        .q_b_o    (core_q_b)
    );

    // After a write-first collision port A's read register already holds the stored word,
    // which is exactly what port B must report.
    assign bus.q_a       = q_valid_q ? core_q_a : '0;
    assign bus.q_b       = !q_valid_q ? '0 :
                           ((RDW_MODE == RDW_WRITE_FIRST) && collision_q) ? core_q_a : core_q_b;
    assign bus.ready     = ready_q;
    assign bus.collision = collision_q;

endmodule
